boa_uart_tx_arbiter: RTL

//   Shares one UART transmit byte stream between NREQ requesters, e.g. CPU

---
 rtl/boa_uart_tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/boa_uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte stream between NREQ requesters.
// A grant is held for a whole message: until a byte flagged last, or an idle timeout.

module boa_uart_tx_arbiter_lane (
  input  logic       sel,
  input  logic       open,
  input  logic       valid,
  input  logic       last,
  input  logic [7:0] data,
  output logic       ready,
  output logic       acc,
  output logic [7:0] acc_data,
  output logic       acc_last
);
  assign ready    = sel & open;
  assign acc      = ready & valid;
  assign acc_data = acc ? data : 8'h00;
  assign acc_last = acc & last;
endmodule

module boa_uart_tx_arbiter #(
  parameter int          NREQ     = 4,
  parameter int          TIMEOUT  = 1024,
  parameter int          TAG_EN   = 0,
  parameter logic [7:0]  TAG_BASE = 8'h80,
  localparam int         IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_evt
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, TAG, DATA} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   idle_cnt;
  logic            slot_free, open, owner_valid;
  logic [NREQ-1:0] lane_acc, lane_last;
  logic [NREQ-1:0][7:0] lane_data;
  logic            any_acc, acc_last;
  logic [7:0]      acc_byte, tag_byte;
  logic            found;
  logic [IW-1:0]   pick, rr_nxt;

  assign slot_free   = !out_valid || out_ready;
  assign open        = (state == DATA) && slot_free;
  assign owner_valid = req_valid[grant_id];
  assign busy        = (state != IDLE);
  assign tag_byte    = TAG_BASE + 8'(grant_id);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    boa_uart_tx_arbiter_lane u_lane (
      .sel      (grant_id == IW'(i)),
      .open     (open),
      .valid    (req_valid[i]),
      .last     (req_last[i]),
      .data     (req_data[8*i +: 8]),
      .ready    (req_ready[i]),
      .acc      (lane_acc[i]),
      .acc_data (lane_data[i]),
      .acc_last (lane_last[i])
    );
  end

  // At most one lane is open, so an OR across lanes acts as the owner mux.
  always_comb begin
    any_acc  = 1'b0;
    acc_last = 1'b0;
    acc_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      any_acc  = any_acc | lane_acc[i];
      acc_last = acc_last | lane_last[i];
      acc_byte = acc_byte | lane_data[i];
    end
  end

  // Scan from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
    rr_nxt = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      grant_id    <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      if (any_acc) begin
        out_valid <= 1'b1;
        out_data  <= acc_byte;
      end else if (state == TAG && slot_free) begin
        out_valid <= 1'b1;
        out_data  <= tag_byte;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: if (found) begin
          grant_id <= pick;
          rr_ptr   <= rr_nxt;
          idle_cnt <= '0;
          state    <= (TAG_EN != 0) ? TAG : DATA;
        end
        TAG: if (slot_free) state <= DATA;
        DATA: begin
          if (any_acc) begin
            idle_cnt <= '0;
            if (acc_last) state <= IDLE;
          end else if (!owner_valid) begin
            // Stalled output with a valid byte is not idle; only a silent owner is.
            if (TIMEOUT != 0 && idle_cnt == TO_LAST) begin
              state       <= IDLE;
              timeout_evt <= 1'b1;
              idle_cnt    <= '0;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
